tlb_search_arb: RTL
===================

TLB_SEARCH_ARB -- requirements
Module: tlb_search_arb

Interface
REQ-001 SHALL: clk  input  1  clock; all state updates on posedge clk.
REQ-002 SHALL: reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL: itlb_req  input  1  ITLB miss search request (level, held until grant).
REQ-004 SHALL: itlb_vpn2  input  19  ITLB search VPN2.
REQ-005 SHALL: dtlb_req  input  1  DTLB miss search request from M1 (level).
REQ-006 SHALL: dtlb_vpn2  input  19  DTLB search VPN2.
REQ-007 SHALL: tlbp_req  input  1  TLBP instruction search request (level).
REQ-008 SHALL: tlbp_vpn2  input  19  EntryHi VPN2 for TLBP.
REQ-009 SHALL: flush  input  1  pipeline flush (exception, eret or refetch).
REQ-010 SHALL: tlb_wr_busy  input  1  TLBWI/TLBWR write in progress; blocks new grants.
REQ-011 SHALL: tlb_s_found  input  1  main TLB hit, valid the cycle after tlb_s_valid.
REQ-012 SHALL: tlb_s_index  input  4  main TLB hit index, same timing as tlb_s_found.
REQ-013 SHALL: tlb_s_valid  output  1  search strobe to main TLB.
REQ-014 SHALL: tlb_s_vpn2  output  19  search VPN2 to main TLB.
REQ-015 SHALL: itlb_grant / dtlb_grant / tlbp_grant  output  1 each  one-cycle grant pulse.
REQ-016 SHALL: itlb_resp / dtlb_resp / tlbp_resp  output  1 each  one-cycle response-valid pulse.
REQ-017 SHALL: resp_found  output  1, resp_index  output  4  registered result, shared by all requesters.
REQ-018 SHALL: busy  output  1  high in any state other than IDLE.

Function
REQ-019 SHALL implement FSM IDLE -> SEARCH -> CAPTURE -> RESP -> IDLE, one cycle per non-IDLE state.
REQ-020 SHALL grant only in IDLE, only when tlb_wr_busy=0 and flush=0; at most one grant per cycle.
REQ-021 SHALL arbitrate TLBP highest priority; between DTLB and ITLB, round-robin using last_served bit.
REQ-022 SHALL give DTLB priority over ITLB when last_served=ITLB, otherwise ITLB, when both are requesting.
REQ-023 SHALL update last_served to the granted DTLB/ITLB owner on grant; TLBP grants leave it unchanged.
REQ-024 SHALL on grant latch owner (2-bit) and the owner's VPN2 into registers, state -> SEARCH.
REQ-025 SHALL in SEARCH drive tlb_s_valid=1 and tlb_s_vpn2=latched VPN2; tlb_s_valid=0 in all other states.
REQ-026 SHALL in CAPTURE register tlb_s_found/tlb_s_index into resp_found/resp_index.
REQ-027 SHALL in RESP assert exactly the owner's resp pulse for one cycle; resp_found/index hold until the next CAPTURE.
REQ-028 SHALL give latency grant cycle N -> tlb_s_valid N+1 -> capture N+2 -> resp N+3; next grant no earlier than N+4.
REQ-029 SHALL on flush=1 in SEARCH, CAPTURE or RESP go to IDLE next cycle, suppressing any resp pulse that cycle or later; latched result not updated after flush.
REQ-030 SHALL ignore requests deasserted before grant (no grant, no state change).
REQ-031 SHALL not let tlb_wr_busy affect an in-flight search.
REQ-032 SHALL assert busy combinationally from state (busy=0 in IDLE).

Reset
REQ-033 SHALL on reset: state=IDLE, owner=none, last_served=ITLB, latched VPN2=0, resp_found=0, resp_index=0, all grant/resp/tlb_s_valid outputs 0.
REQ-034 SHALL make reset dominant over flush and requests in the same cycle, including mid-search.

Verification
REQ-035 SHALL cover single DTLB request: dtlb_req=1, vpn2=0x12345, TLB returns found=1, index=7 -> dtlb_grant cycle 0, tlb_s_valid+vpn2=0x12345 cycle 1, dtlb_resp=1 cycle 3 with resp_found=1, resp_index=7.
REQ-036 SHALL cover contention: itlb_req and dtlb_req held from reset -> DTLB granted first, ITLB granted 4 cycles later; repeat pair alternates DTLB/ITLB.
REQ-037 SHALL cover TLBP priority: tlbp_req, dtlb_req, itlb_req all set -> tlbp_grant first; last_served unchanged (DTLB next).
REQ-038 SHALL cover flush during CAPTURE -> no resp pulse, IDLE next cycle, pending itlb_req granted the following cycle.
REQ-039 SHALL cover tlb_wr_busy=1 for 3 cycles with itlb_req=1 -> no grant until the cycle tlb_wr_busy=0.
REQ-040 SHALL cover reset asserted in SEARCH -> all outputs 0 next cycle, busy=0, no resp pulse.

Source files
------------

// File: rtl/tlb_search_arb.sv
// Arbitrates ITLB-miss, DTLB-miss and TLBP searches onto the single main-TLB search port.
// One search at a time: grant in IDLE, then SEARCH -> CAPTURE -> RESP back to IDLE.
module tlb_search_arb (
  input  logic        clk,
  input  logic        reset,
  input  logic        itlb_req,
  input  logic [18:0] itlb_vpn2,
  input  logic        dtlb_req,
  input  logic [18:0] dtlb_vpn2,
  input  logic        tlbp_req,
  input  logic [18:0] tlbp_vpn2,
  input  logic        flush,
  input  logic        tlb_wr_busy,
  input  logic        tlb_s_found,
  input  logic [3:0]  tlb_s_index,
  output logic        tlb_s_valid,
  output logic [18:0] tlb_s_vpn2,
  output logic        itlb_grant,
  output logic        dtlb_grant,
  output logic        tlbp_grant,
  output logic        itlb_resp,
  output logic        dtlb_resp,
  output logic        tlbp_resp,
  output logic        resp_found,
  output logic [3:0]  resp_index,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SEARCH, CAPTURE, RESP} state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_ITLB = 2'd1;
  localparam logic [1:0] OWN_DTLB = 2'd2;
  localparam logic [1:0] OWN_TLBP = 2'd3;

  state_t      r_state;
  state_t      w_next_state;
  logic [1:0]  r_owner;
  logic        r_last_dtlb;
  logic [18:0] r_vpn2;
  logic        r_resp_found;
  logic [3:0]  r_resp_index;
  logic [1:0]  w_grant_owner;
  logic [18:0] w_grant_vpn2;
  logic        w_can_grant;

  // Round-robin bit: r_last_dtlb=1 means DTLB was served last, so ITLB wins a tie.
  always_comb begin
    w_grant_owner = OWN_NONE;
    w_grant_vpn2  = 19'd0;
    w_can_grant   = (r_state == IDLE) && !tlb_wr_busy && !flush && !reset;
    if (w_can_grant) begin
      if (tlbp_req) begin
        w_grant_owner = OWN_TLBP;
        w_grant_vpn2  = tlbp_vpn2;
      end else if (dtlb_req && itlb_req) begin
        if (r_last_dtlb) begin
          w_grant_owner = OWN_ITLB;
          w_grant_vpn2  = itlb_vpn2;
        end else begin
          w_grant_owner = OWN_DTLB;
          w_grant_vpn2  = dtlb_vpn2;
        end
      end else if (dtlb_req) begin
        w_grant_owner = OWN_DTLB;
        w_grant_vpn2  = dtlb_vpn2;
      end else if (itlb_req) begin
        w_grant_owner = OWN_ITLB;
        w_grant_vpn2  = itlb_vpn2;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_grant_owner != OWN_NONE) w_next_state = SEARCH;
      SEARCH:  w_next_state = flush ? IDLE : CAPTURE;
      CAPTURE: w_next_state = flush ? IDLE : RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_owner      <= OWN_NONE;
      r_last_dtlb  <= 1'b0;
      r_vpn2       <= 19'd0;
      r_resp_found <= 1'b0;
      r_resp_index <= 4'd0;
    end else begin
      r_state <= w_next_state;
      if (w_grant_owner != OWN_NONE) begin
        r_owner <= w_grant_owner;
        r_vpn2  <= w_grant_vpn2;
        if (w_grant_owner != OWN_TLBP) r_last_dtlb <= (w_grant_owner == OWN_DTLB);
      end
      // A flushed search must not overwrite the result the requesters can still see.
      if (r_state == CAPTURE && !flush) begin
        r_resp_found <= tlb_s_found;
        r_resp_index <= tlb_s_index;
      end
    end
  end

  always_comb begin
    itlb_grant  = (w_grant_owner == OWN_ITLB);
    dtlb_grant  = (w_grant_owner == OWN_DTLB);
    tlbp_grant  = (w_grant_owner == OWN_TLBP);
    tlb_s_valid = (r_state == SEARCH) && !reset;
    tlb_s_vpn2  = r_vpn2;
    itlb_resp   = (r_state == RESP) && !flush && !reset && (r_owner == OWN_ITLB);
    dtlb_resp   = (r_state == RESP) && !flush && !reset && (r_owner == OWN_DTLB);
    tlbp_resp   = (r_state == RESP) && !flush && !reset && (r_owner == OWN_TLBP);
    resp_found  = r_resp_found;
    resp_index  = r_resp_index;
    busy        = (r_state != IDLE);
  end

endmodule
